// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter: grant FSM states, bus_owner codes
// and the chip-select split between the memory engine and the peripheral engine.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_MEM = 2'b01,
        OWN_PER = 2'b10,
        GUARD   = 2'b11
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_MEM   = 2'b01;
    localparam logic [1:0] OWNER_PER   = 2'b10;
    localparam logic [1:0] OWNER_GUARD = 2'b11;

    localparam int MEM_CS_W = 2;
    localparam int PER_CS_W = 6;
    localparam int CS_W     = MEM_CS_W + PER_CS_W;

endpackage

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between the memory engine and the peripheral engine with a guard gap.
// Define SPI_ARB_FAIR_EN to let a waiting peripheral win after MAX_MEM_STREAK memory grants.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES   = 2,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req,
    output logic                mem_gnt,
    input  logic                mem_sclk,
    input  logic                mem_mosi,
    output logic                mem_miso,
    input  logic [MEM_CS_W-1:0] mem_cs_n,
    input  logic                per_req,
    output logic                per_gnt,
    input  logic                per_sclk,
    input  logic                per_mosi,
    output logic                per_miso,
    input  logic [PER_CS_W-1:0] per_cs_n,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [CS_W-1:0]     spi_cs_n,
    output logic [1:0]          bus_owner
);

    localparam int GW = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;

    if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 7) begin : g_bad_streak
        $error("MAX_MEM_STREAK must lie in 1..7");
    end

    arb_state_t    state;
    logic [GW-1:0] guard_cnt;
    logic          per_turn;

`ifdef SPI_ARB_FAIR_EN
    logic [2:0] streak;
    assign per_turn = per_req && (int'(streak) >= MAX_MEM_STREAK);
`else
    assign per_turn = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_gnt   <= 1'b0;
            per_gnt   <= 1'b0;
            bus_owner <= OWNER_NONE;
            guard_cnt <= '0;
`ifdef SPI_ARB_FAIR_EN
            streak    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req && !per_turn) begin
                        state     <= OWN_MEM;
                        mem_gnt   <= 1'b1;
                        bus_owner <= OWNER_MEM;
`ifdef SPI_ARB_FAIR_EN
                        // Streak counts only grants taken while the peripheral is waiting.
                        if (!per_req)
                            streak <= '0;
                        else if (streak != '1)
                            streak <= streak + 3'd1;
`endif
                    end else if (per_req) begin
                        state     <= OWN_PER;
                        per_gnt   <= 1'b1;
                        bus_owner <= OWNER_PER;
`ifdef SPI_ARB_FAIR_EN
                        streak    <= '0;
`endif
                    end
                end
                OWN_MEM: begin
                    if (!mem_req) begin
                        mem_gnt <= 1'b0;
                        if (GUARD_CYCLES == 0) begin
                            state     <= IDLE;
                            bus_owner <= OWNER_NONE;
                        end else begin
                            state     <= GUARD;
                            bus_owner <= OWNER_GUARD;
                            guard_cnt <= '0;
                        end
                    end
                end
                OWN_PER: begin
                    if (!per_req) begin
                        per_gnt <= 1'b0;
                        if (GUARD_CYCLES == 0) begin
                            state     <= IDLE;
                            bus_owner <= OWNER_NONE;
                        end else begin
                            state     <= GUARD;
                            bus_owner <= OWNER_GUARD;
                            guard_cnt <= '0;
                        end
                    end
                end
                GUARD: begin
                    if (int'(guard_cnt) >= GUARD_CYCLES - 1) begin
                        state     <= IDLE;
                        bus_owner <= OWNER_NONE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_gnt   <= 1'b0;
                    per_gnt   <= 1'b0;
                    bus_owner <= OWNER_NONE;
                end
            endcase
        end
    end

    // Pads follow the registered owner only; everyone else sees a parked bus.
    always_comb begin
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = '1;
        mem_miso = 1'b0;
        per_miso = 1'b0;
        case (state)
            OWN_MEM: begin
                spi_sclk                 = mem_sclk;
                spi_mosi                 = mem_mosi;
                spi_cs_n[MEM_CS_W-1:0]   = mem_cs_n;
                mem_miso                 = spi_miso;
            end
            OWN_PER: begin
                spi_sclk                     = per_sclk;
                spi_mosi                     = per_mosi;
                spi_cs_n[MEM_CS_W+:PER_CS_W] = per_cs_n;
                per_miso                     = spi_miso;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: two instances (guard gap 2 and 0) share stimulus
// and are compared every cycle against an ownership-level reference model.
module tb_spi_bus_arbiter;

`ifdef SPI_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int MAXS = 4;
    localparam int GV[2] = '{2, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, mem_req, mem_sclk, mem_mosi, per_req, per_sclk, per_mosi, spi_miso;
    logic [1:0] mem_cs_n;
    logic [5:0] per_cs_n;

    logic       mem_gnt[2], per_gnt[2], mem_miso[2], per_miso[2], spi_sclk[2], spi_mosi[2];
    logic [7:0] spi_cs_n[2];
    logic [1:0] bus_owner[2];

    spi_bus_arbiter #(.GUARD_CYCLES(2), .MAX_MEM_STREAK(MAXS)) dut_g2 (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_gnt(mem_gnt[0]), .mem_sclk(mem_sclk), .mem_mosi(mem_mosi),
        .mem_miso(mem_miso[0]), .mem_cs_n(mem_cs_n),
        .per_req(per_req), .per_gnt(per_gnt[0]), .per_sclk(per_sclk), .per_mosi(per_mosi),
        .per_miso(per_miso[0]), .per_cs_n(per_cs_n),
        .spi_sclk(spi_sclk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n[0]), .bus_owner(bus_owner[0])
    );

    spi_bus_arbiter #(.GUARD_CYCLES(0), .MAX_MEM_STREAK(MAXS)) dut_g0 (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_gnt(mem_gnt[1]), .mem_sclk(mem_sclk), .mem_mosi(mem_mosi),
        .mem_miso(mem_miso[1]), .mem_cs_n(mem_cs_n),
        .per_req(per_req), .per_gnt(per_gnt[1]), .per_sclk(per_sclk), .per_mosi(per_mosi),
        .per_miso(per_miso[1]), .per_cs_n(per_cs_n),
        .spi_sclk(spi_sclk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n[1]), .bus_owner(bus_owner[1])
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 mem, 2 per, 3 guard gap),
    // remaining guard cycles and the memory streak while the peripheral waits.
    int m_own[2]    = '{0, 0};
    int m_left[2]   = '{0, 0};
    int m_streak[2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit turn;
            turn = FAIR && per_req && (m_streak[i] >= MAXS);
            if (reset) begin
                m_own[i] = 0; m_left[i] = 0; m_streak[i] = 0;
            end else if (m_own[i] == 0) begin
                if (mem_req && !turn) begin
                    m_own[i] = 1;
                    m_streak[i] = per_req ? ((m_streak[i] < 7) ? m_streak[i] + 1 : 7) : 0;
                end else if (per_req) begin
                    m_own[i] = 2;
                    m_streak[i] = 0;
                end
            end else if ((m_own[i] == 1 && !mem_req) || (m_own[i] == 2 && !per_req)) begin
                m_own[i]  = (GV[i] == 0) ? 0 : 3;
                m_left[i] = GV[i];
            end else if (m_own[i] == 3) begin
                m_left[i]--;
                if (m_left[i] == 0) m_own[i] = 0;
            end
        end
    end

    function automatic logic [15:0] exp_out(input int own);
        logic sclk, mosi, mm, pm;
        logic [7:0] cs;
        sclk = 1'b0; mosi = 1'b0; cs = 8'hFF; mm = 1'b0; pm = 1'b0;
        if (own == 1) begin
            sclk = mem_sclk; mosi = mem_mosi; cs = {6'h3F, mem_cs_n}; mm = spi_miso;
        end else if (own == 2) begin
            sclk = per_sclk; mosi = per_mosi; cs = {per_cs_n, 2'b11}; pm = spi_miso;
        end
        return {own == 1, own == 2, 2'(own), sclk, mosi, cs, mm, pm};
    endfunction

    function automatic logic [15:0] act_out(input int i);
        return {mem_gnt[i], per_gnt[i], bus_owner[i], spi_sclk[i], spi_mosi[i],
                spi_cs_n[i], mem_miso[i], per_miso[i]};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_dut%0d", i), 32'(act_out(i)), 32'(exp_out(m_own[i])));
                check($sformatf("cs_exclusive_dut%0d", i),
                      32'((&spi_cs_n[i][1:0]) | (&spi_cs_n[i][7:2])), 32'd1);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        mem_req = 1'b0; mem_sclk = 1'b0; mem_mosi = 1'b0; mem_cs_n = 2'b11;
        per_req = 1'b0; per_sclk = 1'b0; per_mosi = 1'b0; per_cs_n = 6'h3F;
        spi_miso = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int e0[4] = '{3, 3, 0, 2};
    int e1[4] = '{0, 2, 2, 2};
    int bursts, held, per_at;

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        checking = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("reset_cs", 32'(spi_cs_n[i]), 32'hFF);
            check("reset_owner", 32'(bus_owner[i]), 32'd0);
            check("reset_gnt", 32'({mem_gnt[i], per_gnt[i]}), 32'd0);
        end
        reset = 1'b0;

        // mem alone; peripheral misbehaves as a non-owner
        mem_req = 1'b1; mem_cs_n = 2'b10; mem_sclk = 1'b0; mem_mosi = 1'b1;
        per_cs_n = 6'h00; per_sclk = 1'b1; per_mosi = 1'b1; spi_miso = 1'b1;
        check("gnt_latency", 32'(mem_gnt[0]), 32'd0);
        tick();
        check("mem_gnt", 32'(mem_gnt[0]), 32'd1);
        check("mem_cs", 32'(spi_cs_n[0]), 32'hFE);
        check("mem_sclk_nonowner", 32'(spi_sclk[0]), 32'd0);
        check("mem_mosi", 32'(spi_mosi[0]), 32'd1);
        check("miso_split", 32'({mem_miso[0], per_miso[0]}), 32'b10);
        mem_sclk = 1'b1;
        #1;
        check("mem_sclk_follow", 32'(spi_sclk[0]), 32'd1);

        // simultaneous requests: mem first, guard gap, then per
        do_reset();
        mem_req = 1'b1; per_req = 1'b1;
        tick();
        check("both_mem_first", 32'({mem_gnt[0], per_gnt[0]}), 32'b10);
        mem_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("handover_g2_%0d", k), 32'(bus_owner[0]), 32'(e0[k]));
            check($sformatf("handover_g0_%0d", k), 32'(bus_owner[1]), 32'(e1[k]));
            if (e0[k] == 3) check("guard_cs", 32'(spi_cs_n[0]), 32'hFF);
        end
        check("per_gnt_after_guard", 32'(per_gnt[0]), 32'd1);

        // per waits while mem issues back-to-back bursts
        do_reset();
        per_req = 1'b1; mem_req = 1'b1;
        bursts = 0; held = 0; per_at = -1;
        for (int c = 0; c < 200 && per_at < 0; c++) begin
            tick();
            if (per_gnt[0] && per_at < 0) per_at = bursts;
            if (mem_gnt[0]) begin
                held++;
                if (held == 1) bursts++;
                if (held == 2) mem_req = 1'b0;
            end else begin
                held = 0;
                mem_req = (bursts < 6);
            end
        end
        check("fair_streak", 32'(per_at), FAIR ? 32'd4 : 32'd6);

        // reset while the peripheral owns the bus
        do_reset();
        per_req = 1'b1; per_cs_n = 6'h3E;
        tick();
        check("per_own_cs", 32'(spi_cs_n[0]), 32'hFB);
        reset = 1'b1;
        tick();
        check("rst_mid_cs", 32'(spi_cs_n[0]), 32'hFF);
        check("rst_mid_gnt", 32'(per_gnt[0]), 32'd0);
        check("rst_mid_owner", 32'(bus_owner[0]), 32'd0);
        reset = 1'b0;
        clear_inputs();

        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) mem_req = ~mem_req;
            if ($urandom_range(0, 7) == 0) per_req = ~per_req;
            {mem_sclk, mem_mosi, per_sclk, per_mosi, spi_miso} = 5'($urandom);
            mem_cs_n = 2'($urandom);
            per_cs_n = 6'($urandom);
        end
        tick();
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
